instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction memory. Owns the PC, drives the

---
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly in front of a combinational instruction
//   memory. Owns the PC, presents it as the word address, captures
//   {pc, instruction} pairs into a small FIFO and hands them to decode.
//   A redirect (branch/jump) flushes the FIFO and reloads the PC.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with [1:0]!=0 enters FAULT (fetch_exception=1,
//               no fetching) until an aligned redirect returns to RUN.
//   undefined : target[1:0] is silently masked, fetch_exception tied 0.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   instruction_addr      current PC to instruction memory (word aligned)
//   instruction_read      instruction word returned for instruction_addr
//   instruction_ready     instruction_read valid this cycle
//   redirect_valid/target load target into PC, flush FIFO
//   out_valid/instr/pc    FIFO head to decode
//   out_ready             decode accepts head this cycle
//   fetch_exception       misaligned redirect fault
//   debug_state           FSM state (0 = RUN, 1 = FAULT)
//
// Handshake: an entry transfers to decode on every rising edge where
//   out_valid && out_ready. While out_valid && !out_ready the out_* bus is
//   held stable; out_valid never drops without a transfer except on redirect.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_read,
  input  logic        instruction_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_exception,
  output logic        debug_state
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN   = 1'b0
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_FAULT = 1'b1
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic [31:0]     pc_mem    [QUEUE_DEPTH];
  logic [31:0]     instr_mem [QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            fetch_en;
  logic            push;
  logic            pop;

  assign full      = (count == CW'(QUEUE_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Head is forced to zero when empty so decode never sees stale entries.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;

  assign instruction_addr = pc_q;
  assign debug_state      = state_q;

  // Next-state logic and fetch enable.
  always_comb begin
    state_d  = state_q;
    fetch_en = (state_q == ST_RUN);
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      state_d = (redirect_target[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
`else
      state_d = ST_RUN;
`endif
    end
    // Popping frees a slot this same edge, so a full FIFO can still accept.
    push = fetch_en & instruction_ready & (~full | pop) & ~redirect_valid;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_exception = (state_q == ST_FAULT);
`else
  assign fetch_exception = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, pointers and occupancy. Redirect wins over push; a same-cycle pop is
  // simply absorbed by the flush since decode already took the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_target & 32'hFFFF_FFFC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= instruction_read;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] instruction_addr;
  logic [31:0] instruction_read;
  logic        instruction_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        fetch_exception;
  logic        debug_state;

  instruction_fetch #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .instruction_addr  (instruction_addr),
    .instruction_read  (instruction_read),
    .instruction_ready (instruction_ready),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .out_ready         (out_ready),
    .fetch_exception   (fetch_exception),
    .debug_state       (debug_state)
  );

  // Combinational instruction memory: content is a fixed function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign instruction_read = mem_fn(instruction_addr);

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_q[$];   // {pc, instr}
  logic [31:0] m_pc;
  logic        m_fault;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
  endtask

  task automatic check_state();
    logic [63:0] head;
    chk("instruction_addr", instruction_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("fetch_exception", 32'(fetch_exception), 32'(m_fault));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_pc", out_pc, head[63:32]);
      chk("out_instr", out_instr, head[31:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs, advances the model across the
  // next rising edge, then checks at the following falling edge.
  task automatic step(input logic rdy, input logic ordy, input logic rv,
                      input logic [31:0] rt);
    bit pop, push;
    instruction_ready = rdy;
    out_ready         = ordy;
    redirect_valid    = rv;
    redirect_target   = rt;
    pop  = (exp_q.size() != 0) && ordy;
    push = !m_fault && rdy && (exp_q.size() < DEPTH || pop) && !rv;
    if (pop) void'(exp_q.pop_front());
    if (rv) begin
      exp_q.delete();
      m_pc = rt & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (rt[1:0] != 2'b00);
`endif
    end else if (push) begin
      exp_q.push_back({m_pc, mem_fn(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    instruction_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_addr", instruction_addr, RESET_PC);
    chk("rst_exception", 32'(fetch_exception), 32'd0);
    reset_n = 1'b1;

    // 1: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("t1_out_pc", out_pc, 32'(4 * i));
    end

    // 2: backpressure fills the queue, PC holds, then drains in order
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_pc_hold", instruction_addr, 32'h8);
    chk("t2_head_stable", out_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("t2_drain_pc", out_pc, 32'(4 * (i + 1)));
    end

    // 3: redirect with full queue and a same-cycle pop
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    chk("t3_flushed", 32'(out_valid), 32'd0);
    chk("t3_addr", instruction_addr, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_next_pc", out_pc, 32'h100);

    // 4: PC wrap and hold when memory not ready
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_hold", instruction_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_wrap", instruction_addr, 32'h0);
    chk("t4_head", out_pc, 32'hFFFF_FFFC);

    // 5: asynchronous reset mid-stream
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_addr", instruction_addr, RESET_PC);
    instruction_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // 6: misaligned redirect
    step(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_exc_set", 32'(fetch_exception), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_no_fetch", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("t6_exc_clear", 32'(fetch_exception), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_resume_pc", out_pc, 32'h200);
`else
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_masked_pc", out_pc, 32'h100);
    chk("t6_no_exc", 32'(fetch_exception), 32'd0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
